// File: rtl/wshb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wshb_rr_arbiter                                                 |
// | Purpose  : two-master round-robin Wishbone arbiter in front of one SDRAM   |
// |            slave port; grant is registered and held for a full tenure.     |
// | Option   : WSHB_ARB_QUANTUM_EN forces a handover after QUANTUM acks.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module wshb_rr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef WSHB_ARB_QUANTUM_EN
  ,
  parameter int QUANTUM = 64
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_ms,
  input  logic [3:0]    m0_sel,
  input  logic [2:0]    m0_cti,
  input  logic [1:0]    m0_bte,
  output logic          m0_ack,
  output logic [DW-1:0] m0_dat_sm,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_ms,
  input  logic [3:0]    m1_sel,
  input  logic [2:0]    m1_cti,
  input  logic [1:0]    m1_bte,
  output logic          m1_ack,
  output logic [DW-1:0] m1_dat_sm,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_ms,
  output logic [3:0]    s_sel,
  output logic [2:0]    s_cti,
  output logic [1:0]    s_bte,
  input  logic          s_ack,
  input  logic [DW-1:0] s_dat_sm,
  output logic [1:0]    gnt
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_GNT0 = 2'd1;
  localparam logic [1:0] c_GNT1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_last;
  logic       w_qdone;

`ifdef WSHB_ARB_QUANTUM_EN
  localparam int QW = $clog2(QUANTUM) + 1;
  localparam logic [QW-1:0] c_QLAST = QW'(QUANTUM - 1);
  logic [QW-1:0] r_qcnt;

  assign w_qdone = s_ack && (r_qcnt == c_QLAST);

  // Counter restarts in IDLE, so every tenure begins at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qcnt <= '0;
    end else if (r_state == c_IDLE) begin
      r_qcnt <= '0;
    end else if (s_ack) begin
      r_qcnt <= w_qdone ? '0 : r_qcnt + 1'b1;
    end
  end
`else
  assign w_qdone = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == c_IDLE && w_next == c_GNT0) r_last <= 1'b0;
      if (r_state == c_IDLE && w_next == c_GNT1) r_last <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (m0_cyc && m1_cyc) w_next = r_last ? c_GNT0 : c_GNT1;
        else if (m0_cyc)      w_next = c_GNT0;
        else if (m1_cyc)      w_next = c_GNT1;
      end
      c_GNT0: if (!m0_cyc || (w_qdone && m1_cyc)) w_next = c_IDLE;
      c_GNT1: if (!m1_cyc || (w_qdone && m0_cyc)) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // Slave side is driven only by the owner; a stalled master just never sees ack.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    gnt      = 2'b00;
    case (r_state)
      c_GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        gnt      = 2'b01;
      end
      c_GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        gnt      = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wshb_rr_arbiter.sv
`default_nettype none
// Self-checking bench for wshb_rr_arbiter: directed scenarios plus randomized
// traffic compared every cycle against an owner/last/ack-count model.
module tb_wshb_rr_arbiter;
  localparam int Q = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_adr = 0, m0_dat_ms = 0, m1_adr = 0, m1_dat_ms = 0, s_dat_sm = 0;
  logic [3:0] m0_sel = 0, m1_sel = 0;
  logic [2:0] m0_cti = 0, m1_cti = 0;
  logic [1:0] m0_bte = 0, m1_bte = 0;
  logic s_ack = 0;
  logic m0_ack, m1_ack, s_cyc, s_stb, s_we;
  logic [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms;
  logic [3:0] s_sel;
  logic [2:0] s_cti;
  logic [1:0] s_bte, gnt;

  int checks = 0;
  int errors = 0;

`ifdef WSHB_ARB_QUANTUM_EN
  wshb_rr_arbiter #(.AW(32), .DW(32), .QUANTUM(Q)) dut (
`else
  wshb_rr_arbiter #(.AW(32), .DW(32)) dut (
`endif
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms),
    .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus (-1 none), who owned it last, acks this tenure.
  int owner = -1;
  int last = 1;
  int acks = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= -1;
      last  <= 1;
      acks  <= 0;
    end else if (owner < 0) begin
      if (m0_cyc && m1_cyc) begin
        owner <= (last == 1) ? 0 : 1;
        last  <= (last == 1) ? 0 : 1;
        acks  <= 0;
      end else if (m0_cyc || m1_cyc) begin
        owner <= m0_cyc ? 0 : 1;
        last  <= m0_cyc ? 0 : 1;
        acks  <= 0;
      end
    end else if (!(owner == 0 ? m0_cyc : m1_cyc)) begin
      owner <= -1;
    end else begin
`ifdef WSHB_ARB_QUANTUM_EN
      if (s_ack) begin
        if (acks + 1 == Q) begin
          acks <= 0;
          if (owner == 0 ? m1_cyc : m0_cyc) owner <= -1;
        end else begin
          acks <= acks + 1;
        end
      end
`endif
    end
  end

  function automatic logic [75:0] exp_bus();
    if (owner == 0) return {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte};
    if (owner == 1) return {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte};
    return '0;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("bus", {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte}, exp_bus());
    chk("ack", {m1_ack, m0_ack}, {owner == 1 && s_ack, owner == 0 && s_ack});
    chk("gnt", gnt, {owner == 1, owner == 0});
    chk("rdata", {m1_dat_sm, m0_dat_sm}, {s_dat_sm, s_dat_sm});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    // 1: lone m0 request, grant one clock later, m1 never acked
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_1230; s_ack = 1;
    @(negedge clk); chk("t1_pre_gnt", gnt, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge clk);
      chk("t1_gnt", gnt, 2'b01);
      chk("t1_adr", s_adr, 32'h0000_1230);
      chk("t1_m1_ack", m1_ack, 1'b0);
    end

    // 2: simultaneous first request -> m0, then one IDLE cycle -> m1
    do_reset();
    m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1; s_ack = 0;
    step(); @(negedge clk); chk("t2_first", gnt, 2'b01);
    step(); m0_cyc = 0;
    step(); @(negedge clk); chk("t2_idle_gnt", gnt, 2'b00); chk("t2_idle_cyc", s_cyc, 1'b0);
    step(); @(negedge clk); chk("t2_second", gnt, 2'b10);

    // 3: after an m0 tenure a simultaneous re-request rotates to m1
    do_reset();
    m0_cyc = 1; m1_cyc = 0;
    step(); step(); m0_cyc = 0;
    step(); m0_cyc = 1; m1_cyc = 1;
    @(negedge clk); chk("t3_idle", gnt, 2'b00);
    step(); @(negedge clk); chk("t3_rot", gnt, 2'b10);
    step(); m1_cyc = 0;
    step(); @(negedge clk); chk("t3_idle2", gnt, 2'b00);
    step(); @(negedge clk); chk("t3_back", gnt, 2'b01);

`ifdef WSHB_ARB_QUANTUM_EN
    // 4: always-on m1 is forced off after Q acks
    do_reset();
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    step(); m0_cyc = 1; m0_stb = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != 2'b10) break;
      if (m1_ack) n++;
      step();
    end
    chk("t4_acks", 32'(n), 32'(Q));
    chk("t4_idle", {s_cyc, gnt}, 3'b000);
    step(); @(negedge clk); chk("t4_m0", gnt, 2'b01);
    m0_cyc = 0;
    step(); @(negedge clk); chk("t4_idle2", gnt, 2'b00);
    step(); @(negedge clk); chk("t4_m1_back", gnt, 2'b10);

    // 5: sole requester keeps the grant across quantum boundaries
    do_reset();
    m0_cyc = 0; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("t5_hold", {gnt, m1_ack}, 3'b101);
      step();
    end
`endif

    // 6: asynchronous reset mid-tenure clears outputs immediately
    do_reset();
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    step(); #2;
    chk("t6_pre", gnt, 2'b10);
    rst = 1;
    #1;
    chk("t6_rst", {s_cyc, m1_ack, gnt}, 4'b0000);
    step(); m0_cyc = 1; rst = 0;
    step(); @(negedge clk); chk("t6_tie", gnt, 2'b01);

    // Randomized traffic; cyc tends to persist so tenures are long-ish
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(15) == 0) m1_cyc = ~m1_cyc;
      m0_stb = 1'($urandom); m1_stb = 1'($urandom);
      m0_we = 1'($urandom); m1_we = 1'($urandom);
      m0_adr = $urandom; m1_adr = $urandom;
      m0_dat_ms = $urandom; m1_dat_ms = $urandom;
      m0_sel = 4'($urandom); m1_sel = 4'($urandom);
      m0_cti = 3'($urandom); m1_cti = 3'($urandom);
      m0_bte = 2'($urandom); m1_bte = 2'($urandom);
      s_ack = 1'($urandom); s_dat_sm = $urandom;
      step();
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
